// File: rtl/bcd_serial_sub.sv
// rtl/bcd_serial_sub.sv - digit-serial BCD subtractor (A - B, ten's complement, LSD first)
//
// Purpose:
//   Subtracts two packed-BCD operands one decimal digit per clock, least
//   significant digit first, as a + (9 - b) + carry with an initial carry of 1.
//   The result is presented together with a one-cycle done pulse and is held
//   until the next done or reset.
//
// Ports:
//   clk     in   1          rising-edge clock
//   rst_n   in   1          synchronous reset, active low
//   start   in   1          begin an operation; honoured only when idle
//   a       in   4*DIGITS   minuend, packed BCD (digit i = a[4i+3:4i])
//   b       in   4*DIGITS   subtrahend, packed BCD
//   busy    out  1          high while digits are being processed
//   done    out  1          one-cycle pulse: diff/borrow/err just updated
//   diff    out  4*DIGITS   packed BCD difference (ten's complement when borrow=1)
//   borrow  out  1          1 when a < b
//   err     out  1          1 when any digit of a or b was above 9

module bcd_serial_sub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  borrow,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [W-1:0]       r_a;          // operand copies, shifted right one digit per cycle
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_diff;       // result digits enter at the top and shift down
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_err_acc;

    logic [3:0]         w_a_dig;
    logic [3:0]         w_b_dig;
    logic [3:0]         w_b_nines;
    logic [4:0]         w_sum;
    logic               w_ge10;
    logic [3:0]         w_dig;
    logic               w_dig_bad;
    logic               w_last;

    // The current digit is always the low nibble because the operand
    // registers shift right after every processed digit.
    assign w_a_dig   = r_a[3:0];
    assign w_b_dig   = r_b[3:0];
    // Nine's complement of the subtrahend digit; wraps mod 16 for invalid
    // digits, whose result is discarded anyway.
    assign w_b_nines = 4'd9 - w_b_dig;
    assign w_sum     = {1'b0, w_a_dig} + {1'b0, w_b_nines} + {4'd0, r_carry};
    assign w_ge10    = (w_sum >= 5'd10);
    assign w_dig     = w_ge10 ? 4'(w_sum - 5'd10) : w_sum[3:0];
    assign w_dig_bad = (w_a_dig > 4'd9) | (w_b_dig > 4'd9);
    assign w_last    = (r_idx == IDX_W'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_diff    <= '0;
            r_idx     <= '0;
            r_carry   <= 1'b0;
            r_err_acc <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_diff    <= '0;
                        r_idx     <= '0;
                        r_carry   <= 1'b1;
                        r_err_acc <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a       <= r_a >> 4;
                    r_b       <= r_b >> 4;
                    // After DIGITS shifts the first digit produced sits at the bottom.
                    r_diff    <= (r_diff >> 4) | (W'(w_dig) << (W - 4));
                    r_carry   <= w_ge10;
                    r_err_acc <= r_err_acc | w_dig_bad;
                    r_idx     <= r_idx + 1'b1;
                    if (w_last) begin
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    err     <= r_err_acc;
                    // A final carry of 1 means no borrow out of the top digit.
                    borrow  <= r_err_acc ? 1'b0 : ~r_carry;
                    diff    <= r_err_acc ? '0 : r_diff;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
